// File: rtl/cv32e40x_pkg.sv
// Shared types for the bit-count unit.
// Provides the bitcnt_op_e operation encoding.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    BCNT_CPOP = 2'b00,
    BCNT_CLZ  = 2'b01,
    BCNT_CTZ  = 2'b10,
    BCNT_RSVD = 2'b11
  } bitcnt_op_e;

endpackage

// File: rtl/cv32e40x_popcnt_tree.sv
// Combinational binary adder tree population count.
// Ports: vec_i (WIDTH bits in), cnt_o (RES_W-bit number of ones).
module cv32e40x_popcnt_tree #(
  parameter  int WIDTH = 32,
  localparam int RES_W = $clog2(WIDTH) + 1,
  localparam int LVLS  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [RES_W-1:0] cnt_o
);

  // Level l holds WIDTH>>l partial sums; level 0 is the raw bits.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int N = WIDTH >> l;
    logic [RES_W-1:0] s [N];
    for (genvar j = 0; j < N; j++) begin : g_node
      if (l == 0) begin : g_leaf
        assign s[j] = {{(RES_W-1){1'b0}}, vec_i[j]};
      end else begin : g_add
        assign s[j] = g_lvl[l-1].s[2*j] + g_lvl[l-1].s[2*j+1];
      end
    end
  end

  assign cnt_o = g_lvl[LVLS].s[0];

endmodule

// File: rtl/cv32e40x_bitcnt_unit.sv
// Pipelined CPOP/CLZ/CTZ unit with valid/ready handshake and kill.
// Ports: clk, rst, valid_i/ready_o/op_i/operand_i/id_i in, kill_i,
//        valid_o/ready_i/result_o/id_o out.
module cv32e40x_bitcnt_unit
  import cv32e40x_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int PIPE_REG = 0,
  parameter  int ID_W     = 4,
  localparam int RES_W    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  bitcnt_op_e       op_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic [ID_W-1:0]  id_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [RES_W-1:0] result_o,
  output logic [ID_W-1:0]  id_o
);

  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] vec_d;
  logic [WIDTH-1:0] tree_in;
  logic [RES_W-1:0] cnt;
  logic             in_v;
  logic [ID_W-1:0]  in_id;
  logic             out_free;

  logic             out_v_q;
  logic [RES_W-1:0] res_q;
  logic [ID_W-1:0]  id_q;

  always_comb begin
    rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev[i] = operand_i[WIDTH-1-i];
    end
  end

  // Trailing ones of ~x & (x-1) mark the trailing zeros of x;
  // CLZ reuses this on the reversed operand.
  always_comb begin
    src = (op_i == BCNT_CLZ) ? rev : operand_i;
    unique case (op_i)
      BCNT_CPOP: vec_d = operand_i;
      BCNT_CLZ,
      BCNT_CTZ:  vec_d = ~src & (src - WIDTH'(1));
      default:   vec_d = '0;
    endcase
  end

  assign out_free = !out_v_q || ready_i;

  if (PIPE_REG != 0) begin : g_pipe
    logic             s1_v_q;
    logic [WIDTH-1:0] vec_q;
    logic [ID_W-1:0]  id1_q;

    assign ready_o = !s1_v_q || out_free;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v_q <= 1'b0;
      end else if (kill_i) begin
        s1_v_q <= 1'b0;
      end else if (ready_o) begin
        s1_v_q <= valid_i;
      end
    end

    always_ff @(posedge clk) begin
      if (!kill_i && ready_o && valid_i) begin
        vec_q <= vec_d;
        id1_q <= id_i;
      end
    end

    assign tree_in = vec_q;
    assign in_v    = s1_v_q;
    assign in_id   = id1_q;
  end else begin : g_flat
    assign ready_o = out_free;
    assign tree_in = vec_d;
    assign in_v    = valid_i;
    assign in_id   = id_i;
  end

  cv32e40x_popcnt_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .vec_i (tree_in),
    .cnt_o (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q <= 1'b0;
      res_q   <= '0;
      id_q    <= '0;
    end else if (kill_i) begin
      out_v_q <= 1'b0;
    end else if (out_free) begin
      out_v_q <= in_v;
      if (in_v) begin
        res_q <= cnt;
        id_q  <= in_id;
      end
    end
  end

  assign valid_o  = out_v_q;
  assign result_o = res_q;
  assign id_o     = id_q;

endmodule

// File: tb/tb_cv32e40x_bitcnt_unit.sv
// Bench for cv32e40x_bitcnt_unit: a 32-bit flat and a 64-bit piped
// instance driven by directed scenarios and a random stream.
module tb_cv32e40x_bitcnt_unit;
  import cv32e40x_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  logic       a_vi, a_ro, a_kill, a_vo, a_ri;
  bitcnt_op_e a_op;
  logic [31:0] a_opd;
  logic [3:0] a_idi, a_ido;
  logic [5:0] a_res;

  logic       b_vi, b_ro, b_kill, b_vo, b_ri;
  bitcnt_op_e b_op;
  logic [63:0] b_opd;
  logic [3:0] b_idi, b_ido;
  logic [6:0] b_res;

  cv32e40x_bitcnt_unit #(.WIDTH(32), .PIPE_REG(0), .ID_W(4)) u_a (
    .clk(clk), .rst(rst), .valid_i(a_vi), .ready_o(a_ro),
    .op_i(a_op), .operand_i(a_opd), .id_i(a_idi), .kill_i(a_kill),
    .valid_o(a_vo), .ready_i(a_ri), .result_o(a_res), .id_o(a_ido)
  );

  cv32e40x_bitcnt_unit #(.WIDTH(64), .PIPE_REG(1), .ID_W(4)) u_b (
    .clk(clk), .rst(rst), .valid_i(b_vi), .ready_o(b_ro),
    .op_i(b_op), .operand_i(b_opd), .id_i(b_idi), .kill_i(b_kill),
    .valid_o(b_vo), .ready_i(b_ri), .result_o(b_res), .id_o(b_ido)
  );

  function automatic int ref_cnt(bitcnt_op_e op, logic [63:0] x, int w);
    int n;
    n = 0;
    case (op)
      BCNT_CPOP: for (int i = 0; i < w; i++) n += int'(x[i]);
      BCNT_CTZ: begin
        n = w;
        for (int i = w - 1; i >= 0; i--) if (x[i]) n = i;
      end
      BCNT_CLZ: begin
        n = w;
        for (int i = 0; i < w; i++) if (x[i]) n = w - 1 - i;
      end
      default: n = 0;
    endcase
    return n;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] one;
    one = 64'd1;
    case ($urandom % 4)
      0: return 64'd0;
      1: return one << ($urandom % 64);
      2: return ~(one << ($urandom % 64));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_vi = 0; a_kill = 0; a_ri = 1; a_op = BCNT_CPOP; a_opd = '0; a_idi = '0;
    b_vi = 0; b_kill = 0; b_ri = 1; b_op = BCNT_CPOP; b_opd = '0; b_idi = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    nchk++; if (a_vo !== 1'b0) $display("FAIL rst_a_valid got %0b exp 0", a_vo); else npass++;
    nchk++; if (a_res !== 6'd0) $display("FAIL rst_a_res got %0d exp 0", a_res); else npass++;
    nchk++; if (a_ido !== 4'd0) $display("FAIL rst_a_id got %0d exp 0", a_ido); else npass++;
    nchk++; if (a_ro !== 1'b1) $display("FAIL rst_a_ready got %0b exp 1", a_ro); else npass++;
    nchk++; if (b_vo !== 1'b0) $display("FAIL rst_b_valid got %0b exp 0", b_vo); else npass++;
    nchk++; if (b_res !== 7'd0) $display("FAIL rst_b_res got %0d exp 0", b_res); else npass++;
    nchk++; if (b_ido !== 4'd0) $display("FAIL rst_b_id got %0d exp 0", b_ido); else npass++;
    nchk++; if (b_ro !== 1'b1) $display("FAIL rst_b_ready got %0b exp 1", b_ro); else npass++;
  endtask

  task automatic test_back_to_back();
    bitcnt_op_e ops [3];
    logic [31:0] xs [3];
    int ex [3];
    ops = '{BCNT_CPOP, BCNT_CTZ, BCNT_CLZ};
    xs  = '{32'hFFFF_FFFF, 32'h0000_0100, 32'h0001_0000};
    ex  = '{32, 8, 15};
    idle();
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (c < 3) begin
        a_vi = 1; a_op = ops[c]; a_opd = xs[c]; a_idi = 4'(c + 1);
      end else begin
        a_vi = 0;
      end
      @(negedge clk);
      if (c < 3) begin
        nchk++; if (a_ro !== 1'b1) $display("FAIL b2b_ready c%0d got %0b exp 1", c, a_ro); else npass++;
      end
      if (c >= 1 && c <= 3) begin
        nchk++; if (a_vo !== 1'b1) $display("FAIL b2b_valid c%0d got %0b exp 1", c, a_vo); else npass++;
        nchk++; if (a_res !== 6'(ex[c-1])) $display("FAIL b2b_res c%0d got %0d exp %0d", c, a_res, ex[c-1]); else npass++;
        nchk++; if (a_ido !== 4'(c)) $display("FAIL b2b_id c%0d got %0d exp %0d", c, a_ido, c); else npass++;
      end else begin
        nchk++; if (a_vo !== 1'b0) $display("FAIL b2b_idle c%0d got %0b exp 0", c, a_vo); else npass++;
      end
    end
  endtask

  task automatic test_reserved();
    idle();
    cyc();
    a_vi = 1; a_op = BCNT_RSVD; a_opd = 32'hDEAD_BEEF; a_idi = 4'd5;
    cyc();
    a_vi = 0;
    @(negedge clk);
    nchk++; if (a_vo !== 1'b1) $display("FAIL rsvd_valid got %0b exp 1", a_vo); else npass++;
    nchk++; if (a_res !== 6'd0) $display("FAIL rsvd_res got %0d exp 0", a_res); else npass++;
    nchk++; if (a_ido !== 4'd5) $display("FAIL rsvd_id got %0d exp 5", a_ido); else npass++;
  endtask

  task automatic test_w64();
    bitcnt_op_e ops [3];
    logic [63:0] xs [3];
    int ex [3];
    ops = '{BCNT_CLZ, BCNT_CTZ, BCNT_CPOP};
    xs  = '{64'd0, 64'd0, 64'h8000_0000_0000_0001};
    ex  = '{64, 64, 2};
    idle();
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (c < 3) begin
        b_vi = 1; b_op = ops[c]; b_opd = xs[c]; b_idi = 4'(c + 1);
      end else begin
        b_vi = 0;
      end
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        nchk++; if (b_vo !== 1'b1) $display("FAIL w64_valid c%0d got %0b exp 1", c, b_vo); else npass++;
        nchk++; if (b_res !== 7'(ex[c-2])) $display("FAIL w64_res c%0d got %0d exp %0d", c, b_res, ex[c-2]); else npass++;
        nchk++; if (b_ido !== 4'(c - 1)) $display("FAIL w64_id c%0d got %0d exp %0d", c, b_ido, c - 1); else npass++;
      end else begin
        nchk++; if (b_vo !== 1'b0) $display("FAIL w64_idle c%0d got %0b exp 0", c, b_vo); else npass++;
      end
    end
  endtask

  task automatic test_stall();
    idle();
    b_ri = 0;
    cyc(); b_vi = 1; b_op = BCNT_CTZ; b_opd = 64'h20; b_idi = 4'd7;
    @(negedge clk);
    nchk++; if (b_ro !== 1'b1) $display("FAIL stall_rdy0 got %0b exp 1", b_ro); else npass++;
    nchk++; if (b_vo !== 1'b0) $display("FAIL stall_vld0 got %0b exp 0", b_vo); else npass++;
    cyc(); b_op = BCNT_CPOP; b_opd = 64'hFF; b_idi = 4'd8;
    @(negedge clk);
    nchk++; if (b_ro !== 1'b1) $display("FAIL stall_rdy1 got %0b exp 1", b_ro); else npass++;
    nchk++; if (b_vo !== 1'b0) $display("FAIL stall_vld1 got %0b exp 0", b_vo); else npass++;
    cyc(); b_op = BCNT_CLZ; b_opd = 64'h1_0000_0000; b_idi = 4'd9;
    @(negedge clk);
    nchk++; if (b_ro !== 1'b0) $display("FAIL stall_full got %0b exp 0", b_ro); else npass++;
    nchk++; if (b_vo !== 1'b1) $display("FAIL stall_vld2 got %0b exp 1", b_vo); else npass++;
    nchk++; if (b_res !== 7'd5) $display("FAIL stall_res2 got %0d exp 5", b_res); else npass++;
    nchk++; if (b_ido !== 4'd7) $display("FAIL stall_id2 got %0d exp 7", b_ido); else npass++;
    cyc(); b_ri = 1;
    @(negedge clk);
    nchk++; if (b_ro !== 1'b1) $display("FAIL stall_rel got %0b exp 1", b_ro); else npass++;
    nchk++; if (b_res !== 7'd5) $display("FAIL stall_hold_res got %0d exp 5", b_res); else npass++;
    nchk++; if (b_ido !== 4'd7) $display("FAIL stall_hold_id got %0d exp 7", b_ido); else npass++;
    cyc(); b_vi = 0;
    @(negedge clk);
    nchk++; if (b_vo !== 1'b1) $display("FAIL stall_vld4 got %0b exp 1", b_vo); else npass++;
    nchk++; if (b_res !== 7'd8) $display("FAIL stall_res4 got %0d exp 8", b_res); else npass++;
    nchk++; if (b_ido !== 4'd8) $display("FAIL stall_id4 got %0d exp 8", b_ido); else npass++;
    cyc();
    @(negedge clk);
    nchk++; if (b_vo !== 1'b1) $display("FAIL stall_vld5 got %0b exp 1", b_vo); else npass++;
    nchk++; if (b_res !== 7'd31) $display("FAIL stall_res5 got %0d exp 31", b_res); else npass++;
    nchk++; if (b_ido !== 4'd9) $display("FAIL stall_id5 got %0d exp 9", b_ido); else npass++;
    cyc();
    @(negedge clk);
    nchk++; if (b_vo !== 1'b0) $display("FAIL stall_end got %0b exp 0", b_vo); else npass++;
  endtask

  task automatic test_kill();
    idle();
    b_ri = 0;
    cyc(); b_vi = 1; b_op = BCNT_CPOP; b_opd = 64'h3; b_idi = 4'd1;
    @(negedge clk);
    nchk++; if (b_ro !== 1'b1) $display("FAIL kill_rdy0 got %0b exp 1", b_ro); else npass++;
    cyc(); b_opd = 64'h7; b_idi = 4'd2;
    cyc(); b_opd = 64'hF; b_idi = 4'd3; b_kill = 1;
    @(negedge clk);
    nchk++; if (b_ro !== 1'b0) $display("FAIL kill_full got %0b exp 0", b_ro); else npass++;
    cyc(); b_kill = 0; b_vi = 0; b_ri = 1;
    @(negedge clk);
    nchk++; if (b_vo !== 1'b0) $display("FAIL kill_vld3 got %0b exp 0", b_vo); else npass++;
    nchk++; if (b_ro !== 1'b1) $display("FAIL kill_rdy3 got %0b exp 1", b_ro); else npass++;
    cyc();
    @(negedge clk);
    nchk++; if (b_vo !== 1'b0) $display("FAIL kill_vld4 got %0b exp 0", b_vo); else npass++;
    cyc(); b_vi = 1; b_op = BCNT_CTZ; b_opd = 64'h8000_0000_0000_0000; b_idi = 4'd4;
    @(negedge clk);
    nchk++; if (b_vo !== 1'b0) $display("FAIL kill_vld5 got %0b exp 0", b_vo); else npass++;
    cyc(); b_vi = 0;
    @(negedge clk);
    nchk++; if (b_vo !== 1'b0) $display("FAIL kill_vld6 got %0b exp 0", b_vo); else npass++;
    cyc();
    @(negedge clk);
    nchk++; if (b_vo !== 1'b1) $display("FAIL kill_next_vld got %0b exp 1", b_vo); else npass++;
    nchk++; if (b_res !== 7'd63) $display("FAIL kill_next_res got %0d exp 63", b_res); else npass++;
    nchk++; if (b_ido !== 4'd4) $display("FAIL kill_next_id got %0d exp 4", b_ido); else npass++;
    cyc();
    @(negedge clk);
    nchk++; if (b_vo !== 1'b0) $display("FAIL kill_next_end got %0b exp 0", b_vo); else npass++;
    // kill coinciding with a consumed result must not replay it
    cyc(); a_vi = 1; a_op = BCNT_CPOP; a_opd = 32'h7; a_idi = 4'd11;
    cyc(); a_vi = 0; a_kill = 1;
    @(negedge clk);
    nchk++; if (a_vo !== 1'b1) $display("FAIL killhs_vld got %0b exp 1", a_vo); else npass++;
    nchk++; if (a_res !== 6'd3) $display("FAIL killhs_res got %0d exp 3", a_res); else npass++;
    cyc(); a_kill = 0;
    @(negedge clk);
    nchk++; if (a_vo !== 1'b0) $display("FAIL killhs_after got %0b exp 0", a_vo); else npass++;
  endtask

  task automatic test_rst_stall();
    idle();
    a_ri = 0;
    cyc(); a_vi = 1; a_op = BCNT_CPOP; a_opd = 32'hF; a_idi = 4'd6;
    cyc(); a_vi = 0; rst = 1;
    @(negedge clk);
    nchk++; if (a_vo !== 1'b1) $display("FAIL rsts_pre_vld got %0b exp 1", a_vo); else npass++;
    nchk++; if (a_res !== 6'd4) $display("FAIL rsts_pre_res got %0d exp 4", a_res); else npass++;
    cyc(); rst = 0;
    @(negedge clk);
    nchk++; if (a_vo !== 1'b0) $display("FAIL rsts_vld got %0b exp 0", a_vo); else npass++;
    nchk++; if (a_res !== 6'd0) $display("FAIL rsts_res got %0d exp 0", a_res); else npass++;
    nchk++; if (a_ido !== 4'd0) $display("FAIL rsts_id got %0d exp 0", a_ido); else npass++;
    nchk++; if (a_ro !== 1'b1) $display("FAIL rsts_rdy got %0b exp 1", a_ro); else npass++;
    cyc(); a_ri = 1;
  endtask

  task automatic test_random();
    logic [9:0]  q0 [$];
    logic [10:0] q1 [$];
    logic [9:0]  e0;
    logic [10:0] e1;
    int acc0;
    int dcnt;
    bit drain;
    acc0 = 0;
    dcnt = 0;
    idle();
    for (int n = 0; n < 60000; n++) begin
      drain = (acc0 >= 10000);
      if (drain) begin
        dcnt++;
        if (dcnt > 10) break;
      end
      cyc();
      if (drain) begin
        idle();
      end else begin
        a_vi = ($urandom % 4) != 0; a_op = bitcnt_op_e'($urandom % 4);
        a_opd = 32'(rnd64()); a_idi = 4'($urandom); a_ri = $urandom % 2 == 0;
        a_kill = ($urandom % 50) == 0;
        b_vi = ($urandom % 4) != 0; b_op = bitcnt_op_e'($urandom % 4);
        b_opd = rnd64(); b_idi = 4'($urandom); b_ri = $urandom % 2 == 0;
        b_kill = ($urandom % 50) == 0;
      end
      @(negedge clk);
      if (a_vo && a_ri) begin
        nchk++;
        if (q0.size() == 0) $display("FAIL rnd_a_extra got id %0d res %0d exp none", a_ido, a_res);
        else begin
          e0 = q0.pop_front();
          if ({a_ido, a_res} !== e0)
            $display("FAIL rnd_a got id %0d res %0d exp id %0d res %0d", a_ido, a_res, e0[9:6], e0[5:0]);
          else npass++;
        end
      end
      if (a_kill) q0.delete();
      else if (a_vi && a_ro) begin
        q0.push_back({a_idi, 6'(ref_cnt(a_op, {32'd0, a_opd}, 32))});
        acc0++;
      end
      if (b_vo && b_ri) begin
        nchk++;
        if (q1.size() == 0) $display("FAIL rnd_b_extra got id %0d res %0d exp none", b_ido, b_res);
        else begin
          e1 = q1.pop_front();
          if ({b_ido, b_res} !== e1)
            $display("FAIL rnd_b got id %0d res %0d exp id %0d res %0d", b_ido, b_res, e1[10:7], e1[6:0]);
          else npass++;
        end
      end
      if (b_kill) q1.delete();
      else if (b_vi && b_ro) q1.push_back({b_idi, 7'(ref_cnt(b_op, b_opd, 64))});
    end
    nchk++; if (acc0 < 10000) $display("FAIL rnd_budget got %0d exp 10000", acc0); else npass++;
    nchk++; if (q0.size() != 0) $display("FAIL rnd_a_lost got %0d exp 0", q0.size()); else npass++;
    nchk++; if (q1.size() != 0) $display("FAIL rnd_b_lost got %0d exp 0", q1.size()); else npass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_reserved();
    test_w64();
    test_stall();
    test_kill();
    test_rst_stall();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
